// File: rtl/rs_pkg.sv
// Shared definitions for the RS word assembly path.
package rs_pkg;

  localparam int unsigned RS_WORD_W     = 12;
  localparam int unsigned RS_BEAT_W     = 8;
  localparam int unsigned RS_FIFO_DEPTH = 2;
  localparam logic [3:0]  RS_SYNC_TAG   = 4'hA;

  typedef logic [RS_WORD_W-1:0] rs_word_t;

  typedef enum logic {
    ST_LO,
    ST_HI
  } rs_state_e;

  function automatic logic rs_tag_ok(input logic [3:0] tag, input logic [3:0] sync);
    return tag == sync;
  endfunction

endpackage

// File: rtl/rs_word_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Pointers carry one extra wrap bit to tell full from empty.
// When empty, head shows the last word that was presented.
module rs_word_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? hold_q : mem_q[rd_q[AW-1:0]];

  // Storage, pointers, and last-presented-word register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q   <= '0;
      rd_q   <= '0;
      hold_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_data;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_ONE;
      end
      if (!empty) begin
        hold_q <= mem_q[rd_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/rs_word_assembler.sv
// Assembles 12-bit RS words from pairs of 8-bit beats (LO then tagged HI).
// Words go into a small FWFT FIFO; accepted words and framing errors are counted.
module rs_word_assembler
  import rs_pkg::*;
#(
  parameter int unsigned WORD_W   = RS_WORD_W,
  parameter int unsigned BEAT_W   = RS_BEAT_W,
  parameter int unsigned DEPTH    = RS_FIFO_DEPTH,
  parameter logic [3:0]  SYNC_TAG = RS_SYNC_TAG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic [7:0]        word_cnt,
  output logic [3:0]        err_cnt
);

  rs_state_e         state_q;
  logic [BEAT_W-1:0] lo_q;
  logic              frame_err_q;
  logic [7:0]        word_cnt_q;
  logic [3:0]        err_cnt_q;

  logic              fifo_full, fifo_empty;
  logic              accept, tag_ok, push;
  logic [WORD_W-1:0] push_word;

  // in_ready depends on registered state only; out_ready never reaches it.
  assign in_ready  = (state_q == ST_LO) || !fifo_full;
  assign accept    = in_valid && in_ready;
  assign tag_ok    = rs_tag_ok(in_data[BEAT_W-1:BEAT_W-4], SYNC_TAG);
  assign push      = accept && (state_q == ST_HI) && tag_ok && !flush;
  assign push_word = {in_data[3:0], lo_q};

  // Beat-pairing FSM with LO latch, error pulse and debug counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LO;
      lo_q        <= '0;
      frame_err_q <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else if (flush) begin
      state_q     <= ST_LO;
      lo_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (accept) begin
        if (state_q == ST_LO) begin
          lo_q    <= in_data;
          state_q <= ST_HI;
        end else begin
          state_q <= ST_LO;
          if (tag_ok) begin
            word_cnt_q <= word_cnt_q + 8'd1;
          end else begin
            frame_err_q <= 1'b1;
            if (err_cnt_q != 4'hF) begin
              err_cnt_q <= err_cnt_q + 4'd1;
            end
          end
        end
      end
    end
  end

  rs_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_word),
    .pop       (out_ready),
    .head      (out_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign frame_err = frame_err_q;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rs_word_assembler.sv
// Directed bench for rs_word_assembler. Inputs change 1ns after the rising
// edge; outputs are sampled at that same point or on the falling edge.
module tb_rs_word_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  in_data = 8'hFF;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        frame_err;
  logic [7:0]  word_cnt;
  logic [3:0]  err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rs_word_assembler #(
    .WORD_W   (12),
    .BEAT_W   (8),
    .DEPTH    (2),
    .SYNC_TAG (4'hA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt)
  );

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic beat(input logic [7:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      fails++;
      $display("FAIL beat_timeout: in_ready stayed %b for data %h, required 1", in_ready, d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hFF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_word !== 12'h000) begin fails++; $display("FAIL reset_out_word: got %h want 000", out_word); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests++; if (word_cnt !== 8'h00) begin fails++; $display("FAIL reset_word_cnt: got %h want 00", word_cnt); end
    tests++; if (err_cnt !== 4'h0) begin fails++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_good_word();
    out_ready = 1'b0;
    beat(8'h34);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL good_lo_only_valid: got %b want 0", out_valid); end
    beat(8'hA5);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL good_valid: got %b want 1", out_valid); end
    tests++; if (out_word !== 12'h534) begin fails++; $display("FAIL good_word: got %h want 534", out_word); end
    tests++; if (word_cnt !== 8'd1) begin fails++; $display("FAIL good_word_cnt: got %0d want 1", word_cnt); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL good_frame_err: got %b want 0", frame_err); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL good_pop_valid: got %b want 0", out_valid); end
    tests++; if (out_word !== 12'h534) begin fails++; $display("FAIL good_hold_word: got %h want 534", out_word); end
  endtask

  task automatic test_frame_err();
    beat(8'h34);
    beat(8'hB5);
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
    tests++; if (err_cnt !== 4'd1) begin fails++; $display("FAIL ferr_err_cnt: got %0d want 1", err_cnt); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ferr_no_push: got %b want 0", out_valid); end
    tests++; if (word_cnt !== 8'd1) begin fails++; $display("FAIL ferr_word_cnt: got %0d want 1", word_cnt); end
    @(posedge clk); #1;
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_pulse_end: got %b want 0", frame_err); end
    beat(8'h01);
    beat(8'hA2);
    tests++; if (out_word !== 12'h201) begin fails++; $display("FAIL ferr_recover_word: got %h want 201", out_word); end
    tests++; if (word_cnt !== 8'd2) begin fails++; $display("FAIL ferr_recover_cnt: got %0d want 2", word_cnt); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [11:0] got [8];
    logic        acc;
    int          n;
    out_ready = 1'b0;
    beat(8'h11); beat(8'hA1);
    beat(8'h22); beat(8'hA2);
    beat(8'h33);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    in_data  = 8'hA3;
    in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_stall: got %b want 0", in_ready); end
    tests++; if (word_cnt !== 8'd4) begin fails++; $display("FAIL full_word_cnt: got %0d want 4", word_cnt); end
    tests++; if (out_word !== 12'h111) begin fails++; $display("FAIL full_head: got %h want 111", out_word); end
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && n < 8) begin got[n] = out_word; n++; end
      @(posedge clk); #1;
      if (acc) begin in_valid = 1'b0; in_data = 8'hFF; end
    end
    out_ready = 1'b0;
    tests++; if (n !== 3) begin fails++; $display("FAIL full_drain_count: got %0d want 3", n); end
    tests++; if (got[0] !== 12'h111) begin fails++; $display("FAIL full_order0: got %h want 111", got[0]); end
    tests++; if (got[1] !== 12'h222) begin fails++; $display("FAIL full_order1: got %h want 222", got[1]); end
    tests++; if (got[2] !== 12'h333) begin fails++; $display("FAIL full_order2: got %h want 333", got[2]); end
    tests++; if (word_cnt !== 8'd5) begin fails++; $display("FAIL full_final_cnt: got %0d want 5", word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  lo, hi;
    logic [11:0] exp;
    // One word waiting while the next HI beat arrives with out_ready high.
    out_ready = 1'b0;
    beat(8'h5A); beat(8'hA6);
    beat(8'h7B);
    out_ready = 1'b1;
    beat(8'hA8);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_sim_valid: got %b want 1", out_valid); end
    tests++; if (out_word !== 12'h87B) begin fails++; $display("FAIL b2b_sim_word: got %h want 87B", out_word); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_sim_drained: got %b want 0", out_valid); end
    for (int i = 0; i < 5; i++) begin
      lo  = 8'(i * 16 + 3);
      hi  = 8'hA0 | 8'(i);
      exp = {hi[3:0], lo};
      beat(lo);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_dup%0d: got %b want 0", i, out_valid); end
      beat(hi);
      tests++; if (out_word !== exp || out_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_word%0d: got %h/%b want %h/1", i, out_word, out_valid, exp);
      end
    end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end_empty: got %b want 0", out_valid); end
    tests++; if (word_cnt !== 8'd12) begin fails++; $display("FAIL b2b_word_cnt: got %0d want 12", word_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_flush();
    out_ready = 1'b0;
    beat(8'h12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0 || word_cnt !== 8'd0) begin
      fails++; $display("FAIL rst_mid_state: got valid %b cnt %0d want 0/0", out_valid, word_cnt);
    end
    beat(8'h45); beat(8'hA6);
    tests++; if (out_word !== 12'h645) begin fails++; $display("FAIL rst_lo_discard: got %h want 645", out_word); end
    tests++; if (err_cnt !== 4'd0) begin fails++; $display("FAIL rst_lo_no_err: got %0d want 0", err_cnt); end
    beat(8'h34); beat(8'hB5);
    beat(8'h78); beat(8'hA9);
    beat(8'h12);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_full: got %b want 0", in_ready); end
    flush = 1'b1; in_data = 8'hA1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; in_data = 8'hFF;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tests++; if (word_cnt !== 8'd2) begin fails++; $display("FAIL flush_keep_word_cnt: got %0d want 2", word_cnt); end
    tests++; if (err_cnt !== 4'd1) begin fails++; $display("FAIL flush_keep_err_cnt: got %0d want 1", err_cnt); end
    // Flush wins over a concurrent HI accept.
    out_ready = 1'b1;
    beat(8'h55);
    flush = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; in_data = 8'hFF;
    tests++; if (word_cnt !== 8'd2 || out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_override: got cnt %0d valid %b want 2/0", word_cnt, out_valid);
    end
    beat(8'h66); beat(8'hA7);
    tests++; if (out_word !== 12'h766 || word_cnt !== 8'd3) begin
      fails++; $display("FAIL flush_resume: got %h cnt %0d want 766/3", out_word, word_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_counter_limits();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      beat(8'(i));
      beat(8'hA0 | 8'(i % 16));
    end
    tests++; if (word_cnt !== 8'hFF) begin fails++; $display("FAIL wcnt_255: got %h want FF", word_cnt); end
    beat(8'h00); beat(8'hA0);
    tests++; if (word_cnt !== 8'h00) begin fails++; $display("FAIL wcnt_wrap: got %h want 00", word_cnt); end
    for (int i = 0; i < 15; i++) begin
      beat(8'h00); beat(8'h50);
    end
    tests++; if (err_cnt !== 4'hF) begin fails++; $display("FAIL ecnt_15: got %h want F", err_cnt); end
    beat(8'h00); beat(8'h50);
    beat(8'h00); beat(8'h50);
    tests++; if (err_cnt !== 4'hF) begin fails++; $display("FAIL ecnt_sat: got %h want F", err_cnt); end
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ecnt_pulse_sat: got %b want 1", frame_err); end
    tests++; if (word_cnt !== 8'h00) begin fails++; $display("FAIL ecnt_word_cnt: got %h want 00", word_cnt); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_word();
    test_frame_err();
    test_full();
    test_back_to_back();
    test_rst_flush();
    test_counter_limits();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
